// File: rtl/aes_core_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : aes_core_arbiter_if
//  Brief    : Bundles the requester, cipher-core and response signals of the
//             two-requester AES core arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface aes_core_arbiter_if;
  // Requester side
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req0_data;
  logic [127:0] req1_data;
  logic [127:0] req0_key;
  logic [127:0] req1_key;
  // Shared cipher core side
  logic         core_start;
  logic [127:0] core_din;
  logic [127:0] core_key;
  logic         core_done;
  logic [127:0] core_dout;
  // Response side
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_data;
  logic         resp_id;
  logic         resp_err;
  // Status
  logic         busy;

  // Environment: drives the requests, models the core and consumes responses
  modport master (
    output req_valid, req0_data, req1_data, req0_key, req1_key,
    output core_done, core_dout, resp_ready,
    input  req_ready, core_start, core_din, core_key,
    input  resp_valid, resp_data, resp_id, resp_err, busy
  );

  // Arbiter
  modport slave (
    input  req_valid, req0_data, req1_data, req0_key, req1_key,
    input  core_done, core_dout, resp_ready,
    output req_ready, core_start, core_din, core_key,
    output resp_valid, resp_data, resp_id, resp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/aes_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : aes_core_arbiter
//  Brief    : Round-robin arbiter sharing one AES cipher core between two
//             requesters, with a BUSY timeout that returns an error response.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_core_arbiter #(
  parameter int unsigned TIMEOUT = 16  // legal range 12..255
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_core_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Last timer value before the abort fires
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t       state_q,      state_d;
  logic         grant_q,      grant_d;
  logic         last_grant_q, last_grant_d;
  logic [7:0]   timer_q,      timer_d;
  logic [127:0] core_din_q,   core_din_d;
  logic [127:0] core_key_q,   core_key_d;
  logic [127:0] resp_data_q,  resp_data_d;
  logic         resp_id_q,    resp_id_d;
  logic         resp_err_q,   resp_err_d;

  logic         arb_sel;
  logic [1:0]   grant_ready;

  // Round-robin pick: a tie goes to the requester not served last time,
  // a lone request wins outright.
  always_comb begin
    arb_sel = 1'b0;
    if (bus.req_valid == 2'b11) begin
      arb_sel = ~last_grant_q;
    end else begin
      arb_sel = bus.req_valid[1];
    end
  end

  // Next-state, datapath capture and combinational accept
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    core_din_d   = core_din_q;
    core_key_d   = core_key_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_err_d   = resp_err_q;
    grant_ready  = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid != 2'b00) begin
          grant_ready = arb_sel ? 2'b10 : 2'b01;
          grant_d     = arb_sel;
          core_din_d  = arb_sel ? bus.req1_data : bus.req0_data;
          core_key_d  = arb_sel ? bus.req1_key  : bus.req0_key;
          state_d     = ST_START;
        end
      end

      ST_START: begin
        timer_d = 8'd0;
        state_d = ST_BUSY;
      end

      ST_BUSY: begin
        timer_d = timer_q + 8'd1;
        // A completion in the final timer cycle still counts as success
        if (bus.core_done) begin
          resp_data_d = bus.core_dout;
          resp_err_d  = 1'b0;
          resp_id_d   = grant_q;
          state_d     = ST_RESP;
        end else if (timer_q == TIMER_LAST) begin
          resp_data_d = 128'd0;
          resp_err_d  = 1'b1;
          resp_id_d   = grant_q;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= 8'd0;
      core_din_q   <= 128'd0;
      core_key_q   <= 128'd0;
      resp_data_q  <= 128'd0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      core_din_q   <= core_din_d;
      core_key_q   <= core_key_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Strobes are decoded straight from the state register
  assign bus.req_ready  = grant_ready;
  assign bus.core_start = (state_q == ST_START);
  assign bus.core_din   = core_din_q;
  assign bus.core_key   = core_key_q;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_core_arbiter
//  Brief    : Directed self-checking bench for aes_core_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_core_arbiter;

  localparam int unsigned TIMEOUT = 16;

  localparam logic [127:0] D0 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] K0 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] D1 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
  localparam logic [127:0] K1 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  aes_core_arbiter_if bus ();

  aes_core_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction: request, core run, optional backpressure, handshake.
  // done_after counts cycles after the core_start cycle (0 = core never answers).
  task automatic run_txn(input logic [1:0] vld, input int done_after,
                         input logic [127:0] dout, input logic exp_id,
                         input logic exp_err, input int stall);
    int           cyc;
    int           exp_lat;
    logic         bad;
    logic [127:0] exp_data;
    logic [127:0] snap_data;
    logic         snap_id;
    logic         snap_err;

    exp_lat  = (done_after > 0) ? done_after + 1 : int'(TIMEOUT) + 1;
    exp_data = exp_err ? 128'd0 : dout;

    // Accept cycle
    @(negedge clk);
    bus.req_valid = vld;
    #1;
    check("req_ready_grant", 128'(bus.req_ready), 128'(exp_id ? 2'b10 : 2'b01));

    // START cycle
    @(negedge clk);
    bus.req_valid = 2'b00;
    check("core_start", 128'(bus.core_start), 128'd1);
    check("core_din", bus.core_din, exp_id ? D1 : D0);
    check("core_key", bus.core_key, exp_id ? K1 : K0);

    // BUSY until a response shows up, bounded
    cyc = 0;
    bad = 1'b0;
    while (!bus.resp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.core_start) bad = 1'b1;
      if (cyc == done_after) begin
        bus.core_done = 1'b1;
        bus.core_dout = dout;
      end else begin
        bus.core_done = 1'b0;
        bus.core_dout = ~dout;
      end
    end
    bus.core_done = 1'b0;
    check("resp_latency", 128'(cyc), 128'(exp_lat));
    check("single_start", 128'(bad), 128'd0);
    check("resp_data", bus.resp_data, exp_data);
    check("resp_id", 128'(bus.resp_id), 128'(exp_id));
    check("resp_err", 128'(bus.resp_err), 128'(exp_err));

    // Backpressure: outputs frozen, no new accept, no core start
    bus.req_valid = 2'b11;
    bus.core_done = 1'b1;
    #1;
    check("req_ready_in_resp", 128'(bus.req_ready), 128'd0);
    snap_data = bus.resp_data;
    snap_id   = bus.resp_id;
    snap_err  = bus.resp_err;
    bad       = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bus.resp_data !== snap_data || bus.resp_id !== snap_id ||
          bus.resp_err !== snap_err || bus.resp_valid !== 1'b1 ||
          bus.req_ready !== 2'b00 || bus.core_start !== 1'b0) bad = 1'b1;
    end
    if (stall > 0) check("bp_stable", 128'(bad), 128'd0);

    // Handshake, then back in IDLE
    bus.core_done  = 1'b0;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("idle_after_hs", 128'({bus.resp_valid, bus.busy}), 128'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_resp_valid", 128'(bus.resp_valid), 128'd0);
    check("rst_core_start", 128'(bus.core_start), 128'd0);
    check("rst_core_din", bus.core_din, 128'd0);
    check("rst_core_key", bus.core_key, 128'd0);
    check("rst_resp", 128'({bus.resp_data, bus.resp_id, bus.resp_err} != 130'd0), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic bad;
    n_vec          = 0;
    n_miss         = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req0_data  = D0;
    bus.req0_key   = K0;
    bus.req1_data  = D1;
    bus.req1_key   = K1;
    bus.core_done  = 1'b0;
    bus.core_dout  = 128'd0;
    bus.resp_ready = 1'b0;

    apply_reset();

    // Tie after reset: requester 0 first, then requester 1
    run_txn(2'b11, 5, 128'h11111111_22222222_33333333_44444444, 1'b0, 1'b0, 0);
    run_txn(2'b11, 5, 128'h55555555_66666666_77777777_88888888, 1'b1, 1'b0, 0);
    // Single request, core answers 10 cycles after start
    run_txn(2'b01, 10, 128'h3925841d_02dc09fb_dc118597_196a0b32, 1'b0, 1'b0, 0);
    // Lone requester 1 and core never answers: timeout error
    run_txn(2'b10, 0, 128'hffffffff_ffffffff_ffffffff_ffffffff, 1'b1, 1'b1, 0);
    // Backpressure for 5 cycles
    run_txn(2'b01, 3, 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0, 1'b0, 1'b0, 5);
    // Done on the last timer cycle wins over timeout
    run_txn(2'b10, 16, 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a, 1'b1, 1'b0, 0);
    // Minimum latency
    run_txn(2'b01, 1, 128'h0badf00d_0badf00d_0badf00d_0badf00d, 1'b0, 1'b0, 2);

    // Reset while BUSY aborts with no response
    @(negedge clk);
    bus.req_valid = 2'b10;
    @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (3) @(negedge clk);
    check("busy_before_rst", 128'(bus.busy), 128'd1);
    apply_reset();
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.core_done = (i == 2);
      if (bus.resp_valid || bus.busy) bad = 1'b1;
    end
    bus.core_done = 1'b0;
    check("no_resp_after_rst", 128'(bad), 128'd0);
    // last_grant back to its reset value: tie goes to requester 0
    run_txn(2'b11, 4, 128'hcafebabe_cafebabe_cafebabe_cafebabe, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard stop in case something stalls outside the bounded loops
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Parameters
REQ-001 SHALL have parameter TIMEOUT, default 16: max BUSY cycles waiting for core_done before abort; legal range 12..255.

Interface
REQ-002 SHALL have port clk, input, 1: clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 2: per-requester request valid (bit 0 = requester 0).
REQ-005 SHALL have port req_ready, output, 2: per-requester accept, one-hot or zero.
REQ-006 SHALL have ports req0_data and req1_data, input, 128 each: plaintext per requester.
REQ-007 SHALL have ports req0_key and req1_key, input, 128 each: cipher key per requester.
REQ-008 SHALL have port core_start, output, 1: single-cycle start pulse to the shared cipher core.
REQ-009 SHALL have port core_din, output, 128: registered plaintext to the core.
REQ-010 SHALL have port core_key, output, 128: registered key to the core.
REQ-011 SHALL have port core_done, input, 1: core completion strobe.
REQ-012 SHALL have port core_dout, input, 128: core ciphertext, valid with core_done.
REQ-013 SHALL have port resp_valid, output, 1: response valid.
REQ-014 SHALL have port resp_ready, input, 1: response consumer accept.
REQ-015 SHALL have port resp_data, output, 128: ciphertext, or zero on error.
REQ-016 SHALL have port resp_id, output, 1: requester index of the response.
REQ-017 SHALL have port resp_err, output, 1: timeout abort flag, qualified by resp_valid.
REQ-018 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> START -> BUSY -> RESP -> IDLE, binary encoded, registered.
REQ-020 In IDLE with req_valid != 0, SHALL grant one requester, assert req_ready for that bit only (combinational, same cycle), latch its data/key into core_din/core_key and grant into a grant register, and go to START.
REQ-021 Arbitration SHALL be round-robin: with both valid, the requester not recorded in last_grant wins; with one valid, it wins regardless of last_grant.
REQ-022 req_ready SHALL be 0 in every state except IDLE.
REQ-023 In START, core_start SHALL be 1 for exactly that cycle; timer SHALL clear to 0; next state BUSY.
REQ-024 In BUSY, timer SHALL increment by 1 per cycle (8-bit, no wrap reached within range).
REQ-025 In BUSY, if core_done=1: resp_data <= core_dout, resp_err <= 0, resp_id <= grant, go RESP; core_done has priority over timeout in the same cycle.
REQ-026 In BUSY, if core_done=0 and timer == TIMEOUT-1: resp_data <= 0, resp_err <= 1, resp_id <= grant, go RESP.
REQ-027 core_done SHALL be ignored in IDLE, START and RESP.
REQ-028 In RESP, resp_valid SHALL be 1 and resp_data/resp_id/resp_err SHALL hold stable until resp_ready=1; on that cycle last_grant <= grant, next state IDLE.
REQ-029 Minimum request-to-response latency SHALL be 3 cycles (accept, START, BUSY with done); new request accepted no earlier than the cycle after the resp handshake.
REQ-030 core_din/core_key SHALL hold value from accept until next accept.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, core_start=0, resp_valid=0, resp_err=0, resp_id=0, resp_data=0, core_din=0, core_key=0, timer=0, grant=0, last_grant=1 (requester 0 wins first tie).
REQ-032 Reset mid-operation SHALL abort the transaction with no response produced; first cycle after release behaves as IDLE.

Verification
REQ-033 Single request: req_valid=01, core_done 10 cycles after core_start with core_dout=X -> req_ready=01 one cycle, one core_start pulse, resp_valid with resp_data=X, resp_id=0, resp_err=0.
REQ-034 Tie after reset: req_valid=11 held for two transactions -> first grant requester 0, second requester 1, resp_id 0 then 1.
REQ-035 Timeout: core_done never asserted, TIMEOUT=16 -> resp_valid 16 BUSY cycles after START, resp_err=1, resp_data=0.
REQ-036 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_* stable, req_ready=00, no core_start; handshake on cycle 6 returns to IDLE.
REQ-037 Done/timeout collision: core_done=1 on cycle timer==TIMEOUT-1 -> resp_err=0, resp_data=core_dout.
REQ-038 Reset in BUSY: rst_n low 2 cycles -> all outputs at reset values, no resp_valid, next request accepted normally.
